// File: rtl/edge_log_pkg.sv
`default_nettype none
//==============================================================================
// Package  : edge_log_pkg
// Brief    : Shared types for the edge time logger: entry width helper, the
//            change flags portion of a log entry and the capture state encoding.
// Revision : 1.0 - initial release
//==============================================================================
package edge_log_pkg;

    // Mask nibble plus value nibble appended below the timestamp
    localparam int c_FLAG_W = 8;

    // Full entry width {ts, mask, value} for a given timestamp width
    function automatic int entry_w(input int ts_w);
        return ts_w + c_FLAG_W;
    endfunction

    // Capture state
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Low part of an entry; the timestamp is prepended where its width is known
    typedef struct packed {
        logic [3:0] mask;
        logic [3:0] value;
    } edge_flags_t;

endpackage
`default_nettype wire

// File: rtl/edge_log_fifo.sv
`default_nettype none
//==============================================================================
// Module   : edge_log_fifo
// Brief    : DEPTH x WIDTH first-word-fall-through FIFO with synchronous clear.
//            Push while full is accepted when a pop happens in the same cycle.
//            When empty, pop_data keeps showing the most recently popped word.
// Revision : 1.0 - initial release
//==============================================================================
module edge_log_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int c_AW = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_PTR_ONE = 1;
    localparam logic [c_AW-1:0] c_IDX_ONE = 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic [c_AW-1:0]  w_wr_idx;
    logic [c_AW-1:0]  w_rd_idx;
    logic [c_AW-1:0]  w_last_idx;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_wr_idx   = r_wr_ptr[c_AW-1:0];
    assign w_rd_idx   = r_rd_ptr[c_AW-1:0];
    assign w_last_idx = w_rd_idx - c_IDX_ONE;
    assign empty      = (r_wr_ptr == r_rd_ptr);
    assign full       = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) && (w_wr_idx == w_rd_idx);
    assign w_do_pop   = pop && !empty;
    assign w_do_push  = push && (!full || w_do_pop);
    // Slot behind the read pointer is the last head once the FIFO drains
    assign pop_data   = empty ? r_mem[w_last_idx] : r_mem[w_rd_idx];

    // Pointer update; clear restarts at slot 0 and may take a push at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (clr) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= push ? c_PTR_ONE : '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
    end

    // Storage write; reset zeroes it so the output reads 0 after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (clr) begin
            if (push) r_mem[0] <= push_data;
        end else if (w_do_push) begin
            r_mem[w_wr_idx] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/edge_time_logger.sv
`default_nettype none
//==============================================================================
// Module   : edge_time_logger
// Brief    : Samples 4 lines each clock, timestamps every value change with a
//            cycle counter and queues {ts, mask, value} entries for readout.
// Config   : EDGE_TIME_LOGGER_SYNC_EN - pass sig_in through a 2-flop
//            synchronizer first (logged ts becomes 2 cycles late).
// Revision : 1.0 - initial release
//==============================================================================
module edge_time_logger
    import edge_log_pkg::*;
#(
    parameter int TS_W  = 16,
    parameter int DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      sig_in,
    input  logic            start,
    input  logic            stop,
    output logic            rd_valid,
    input  logic            rd_ready,
    output logic [TS_W+7:0] rd_data,
    output logic            armed,
    output logic            overflow,
    output logic            ts_sat
);
    localparam int c_ENTRY_W = entry_w(TS_W);
    localparam logic [TS_W-1:0] c_TS_MAX = {TS_W{1'b1}};
    localparam logic [TS_W-1:0] c_TS_ONE = 1;

    typedef struct packed {
        logic [TS_W-1:0] ts;
        edge_flags_t     flags;
    } entry_t;

    state_t          r_state;
    logic [TS_W-1:0] r_ts;
    logic [3:0]      r_prev;
    logic            r_armed;
    logic            r_overflow;
    logic            r_ts_sat;

    logic [3:0]      w_sample;
    logic [3:0]      w_mask;
    logic [TS_W-1:0] w_ts_next;
    logic            w_start_acc;
    logic            w_log;
    logic            w_sat_hit;
    logic            w_drop;
    logic            w_push;
    logic            w_full;
    logic            w_empty;
    entry_t          w_push_entry;

`ifdef EDGE_TIME_LOGGER_SYNC_EN
    logic [3:0] r_sync1;
    logic [3:0] r_sync2;

    // Two-flop synchronizer for asynchronous monitored lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 4'b0000;
            r_sync2 <= 4'b0000;
        end else begin
            r_sync1 <= sig_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sample = r_sync2;
`else
    assign w_sample = sig_in;
`endif

    // The timestamp of an edge is the counter value that edge produces
    assign w_start_acc = start && (r_state != ST_ARMED);
    assign w_mask      = w_sample ^ r_prev;
    assign w_ts_next   = (r_ts == c_TS_MAX) ? r_ts : r_ts + c_TS_ONE;
    assign w_log       = (r_state == ST_ARMED) && (w_mask != 4'b0000);
    assign w_sat_hit   = (r_state == ST_ARMED) && (w_ts_next == c_TS_MAX);
    // Full with a simultaneous pop is not a drop
    assign w_drop      = w_log && w_full && !rd_ready;
    assign w_push      = w_start_acc || w_log;

    assign w_push_entry.ts          = w_start_acc ? '0 : w_ts_next;
    assign w_push_entry.flags.mask  = w_start_acc ? 4'b0000 : w_mask;
    assign w_push_entry.flags.value = w_sample;

    // Capture FSM with timestamp counter, change tracking and sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_ts       <= '0;
            r_prev     <= 4'b0000;
            r_armed    <= 1'b0;
            r_overflow <= 1'b0;
            r_ts_sat   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state    <= ST_ARMED;
                        r_armed    <= 1'b1;
                        r_ts       <= '0;
                        r_prev     <= w_sample;
                        r_overflow <= 1'b0;
                        r_ts_sat   <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    r_ts <= w_ts_next;
                    if (w_log)     r_prev     <= w_sample;
                    if (w_drop)    r_overflow <= 1'b1;
                    if (w_sat_hit) r_ts_sat   <= 1'b1;
                    if (stop || w_sat_hit) begin
                        r_state <= ST_DONE;
                        r_armed <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_armed <= 1'b0;
                end
            endcase
        end
    end

    edge_log_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (w_start_acc),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (rd_ready),
        .pop_data  (rd_data),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign rd_valid = !w_empty;
    assign armed    = r_armed;
    assign overflow = r_overflow;
    assign ts_sat   = r_ts_sat;

endmodule
`default_nettype wire

// File: tb/tb_edge_time_logger.sv
`default_nettype none
//==============================================================================
// Module   : tb_edge_time_logger
// Brief    : Self-checking bench: directed scenarios plus a randomized run
//            against a queue-based reference model of the change log.
// Config   : EDGE_TIME_LOGGER_SYNC_EN shifts expected timestamps by 2.
// Revision : 1.0 - initial release
//==============================================================================
module tb_edge_time_logger;
    localparam int TS_W  = 16;
    localparam int DEPTH = 8;
    localparam int EW    = TS_W + 8;
`ifdef EDGE_TIME_LOGGER_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    sig_in;
    logic          start, stop, rd_ready;
    logic          rd_valid, armed, overflow, ts_sat;
    logic [EW-1:0] rd_data;
    logic          start4, stop4, rd_ready4;
    logic          rd_valid4, armed4, overflow4, ts_sat4;
    logic [11:0]   rd_data4;

    int tests = 0;
    int fails = 0;
    int cur_e = 0;

    typedef struct {
        logic [15:0] ts;
        logic [3:0]  mask;
        logic [3:0]  val;
    } ent_t;

    typedef struct {
        int         e;
        logic [3:0] sig;
        logic [3:0] mask;
    } vec_t;

    ent_t expq[$];

    edge_time_logger #(.TS_W(TS_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start), .stop(stop),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .armed(armed), .overflow(overflow), .ts_sat(ts_sat)
    );

    edge_time_logger #(.TS_W(4), .DEPTH(DEPTH)) dut4 (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start4), .stop(stop4),
        .rd_valid(rd_valid4), .rd_ready(rd_ready4), .rd_data(rd_data4),
        .armed(armed4), .overflow(overflow4), .ts_sat(ts_sat4)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [EW-1:0] pk(input ent_t e);
        return {e.ts, e.mask, e.val};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cur_e++;
    endtask

    // Leaves the bench just before edge n (edge n-1 already taken)
    task automatic goto_edge(input int n);
        while (cur_e < n - 1) tick();
    endtask

    task automatic arm(input logic [3:0] s);
        sig_in = s;
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        cur_e = 0;
    endtask

    task automatic stop_pulse();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic drain(input string nm);
        rd_ready = 1'b1;
        foreach (expq[i]) begin
            chk($sformatf("%s valid %0d", nm, i), rd_valid, 1);
            chk($sformatf("%s entry %0d", nm, i), rd_data, pk(expq[i]));
            tick();
        end
        rd_ready = 1'b0;
        chk($sformatf("%s empty", nm), rd_valid, 0);
        expq.delete();
    endtask

    initial begin
        vec_t       s1 [3];
        logic [3:0] s;
        logic [3:0] mprev;
        logic       mo;
        bit         popped;
        logic [3:0] hist[$];
        ent_t       mq[$];

        s1[0] = '{10, 4'b0100, 4'b0100};
        s1[1] = '{15, 4'b0101, 4'b0001};
        s1[2] = '{35, 4'b0100, 4'b0001};

        rst_n = 1'b0; sig_in = 4'b0000; start = 1'b0; stop = 1'b0; rd_ready = 1'b0;
        start4 = 1'b0; stop4 = 1'b0; rd_ready4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset rd_valid", rd_valid, 0);
        chk("reset rd_data", rd_data, 0);
        chk("reset armed", armed, 0);
        chk("reset overflow", overflow, 0);
        chk("reset ts_sat", ts_sat, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Scenario 1: replay stimulus, start ignored while armed, start+stop -> stop
        arm(4'b0000);
        chk("s1 armed", armed, 1);
        expq.push_back('{16'd0, 4'b0000, 4'b0000});
        for (int i = 0; i < 3; i++) begin
            if (s1[i].e == 20 + 100) chk("unused", 0, 0);
            goto_edge(s1[i].e);
            sig_in = s1[i].sig;
            expq.push_back('{16'(s1[i].e + L), s1[i].mask, s1[i].sig});
            if (i == 1) begin
                goto_edge(20);
                start = 1'b1;
                tick();
                start = 1'b0;
                chk("s1 start in armed ignored", armed, 1);
            end
        end
        goto_edge(40);
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("s1 stop wins", armed, 0);
        drain("s1");

        // Scenario 2: all four bits change together -> one entry
        arm(4'b0000);
        goto_edge(5);
        sig_in = 4'b1111;
        goto_edge(10);
        stop_pulse();
        expq.push_back('{16'd0, 4'b0000, 4'b0000});
        expq.push_back('{16'(5 + L), 4'b1111, 4'b1111});
        drain("s2");

        // Scenario 3: overflow with no reads
        arm(4'b0000);
        for (int i = 1; i <= 10; i++) begin
            goto_edge(i);
            sig_in[0] = ~sig_in[0];
        end
        goto_edge(10 + L + 1);
        chk("s3 overflow", overflow, 1);
        stop_pulse();
        expq.push_back('{16'd0, 4'b0000, 4'b0000});
        for (int i = 1; i <= 7; i++) expq.push_back('{16'(i + L), 4'b0001, 4'(i % 2)});
        drain("s3");
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("s3 pop on empty", rd_valid, 0);

        // Scenario 4: full FIFO, change and pop on the same edge
        arm(4'b0000);
        chk("s4 overflow cleared by arm", overflow, 0);
        for (int i = 1; i <= 8; i++) begin
            goto_edge(i);
            sig_in[0] = ~sig_in[0];
        end
        goto_edge(8 + L);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("s4 overflow", overflow, 0);
        goto_edge(14);
        stop_pulse();
        for (int i = 1; i <= 8; i++) expq.push_back('{16'(i + L), 4'b0001, 4'(i % 2)});
        drain("s4");

        // Scenario 5: 4-bit timestamp saturation, then re-arm
        sig_in = 4'b0000;
        repeat (3) tick();
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        cur_e = 0;
        goto_edge(15 - L);
        sig_in = 4'b1000;
        goto_edge(15);
        chk("s5 armed before sat", armed4, 1);
        chk("s5 ts_sat before sat", ts_sat4, 0);
        tick();
        chk("s5 ts_sat", ts_sat4, 1);
        chk("s5 done", armed4, 0);
        sig_in = 4'b0001;
        repeat (4) tick();
        chk("s5 baseline", rd_data4, 12'h000);
        rd_ready4 = 1'b1;
        tick();
        rd_ready4 = 1'b0;
        chk("s5 sat entry", rd_data4, {4'hF, 4'b1000, 4'b1000});
        sig_in = 4'b0011;
        repeat (3) tick();
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        chk("s5 rearm armed", armed4, 1);
        chk("s5 rearm ts_sat", ts_sat4, 0);
        chk("s5 rearm head", rd_data4, {4'h0, 4'b0000, 4'b0011});
        rd_ready4 = 1'b1;
        tick();
        rd_ready4 = 1'b0;
        chk("s5 rearm cleared", rd_valid4, 0);

        // Scenario 6: asynchronous reset mid-capture
        arm(4'b0010);
        goto_edge(2);
        sig_in = 4'b0011;
        goto_edge(4);
        sig_in = 4'b0111;
        goto_edge(6 + L);
        chk("s6 armed pre", armed, 1);
        chk("s6 head pre", rd_data, {16'd0, 4'b0000, 4'b0010});
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6 rd_valid", rd_valid, 0);
        chk("s6 rd_data", rd_data, 0);
        chk("s6 armed", armed, 0);
        chk("s6 overflow", overflow, 0);
        chk("s6 ts_sat", ts_sat, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Randomized run against the queue model
        sig_in = 4'($urandom);
        repeat (3) tick();
        hist = {sig_in, sig_in, sig_in};
        start = 1'b1;
        tick();
        start = 1'b0;
        mprev = hist[hist.size() - 1 - L];
        mq.push_back('{16'd0, 4'b0000, mprev});
        mo = 1'b0;
        for (int n = 1; n <= 400; n++) begin
            chk("rnd rd_valid", rd_valid, (mq.size() != 0));
            if (mq.size() != 0) chk("rnd rd_data", rd_data, pk(mq[0]));
            chk("rnd overflow", overflow, mo);
            if ($urandom_range(0, 3) == 0) sig_in = 4'($urandom);
            rd_ready = (n < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            hist.push_back(sig_in);
            popped = rd_ready && (mq.size() != 0);
            tick();
            if (popped) void'(mq.pop_front());
            s = hist[hist.size() - 1 - L];
            if (s != mprev) begin
                if (mq.size() < DEPTH) mq.push_back('{16'(n), s ^ mprev, s});
                else mo = 1'b1;
                mprev = s;
            end
        end
        rd_ready = 1'b0;
        stop_pulse();
        chk("rnd stopped", armed, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
